word_byte_unpacker: RTL and testbench

//  Reader side of the 32-bit load register path. Accepts one NUM_LANES*LANE_W

---
 rtl/word_byte_unpacker.sv | 101 ++++++++++
 tb/tb_word_byte_unpacker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_unpacker.sv
// Splits a NUM_LANES*LANE_W word into lanes, lane 0 first, over valid/ready handshakes.
// Optional feature macro: UNPACK_MASK_EN adds the In_Mask port for sparse lane emission.
module word_byte_unpacker #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           In_Valid,
    output logic                           In_Ready,
    input  logic [NUM_LANES*LANE_W-1:0]    In_Data,
`ifdef UNPACK_MASK_EN
    input  logic [NUM_LANES-1:0]           In_Mask,
`endif
    output logic                           Out_Valid,
    input  logic                           Out_Ready,
    output logic [LANE_W-1:0]              Out_Data,
    output logic [$clog2(NUM_LANES)-1:0]   Out_Lane,
    output logic                           Out_Last
);

    localparam int W     = NUM_LANES * LANE_W;
    localparam int IDX_W = $clog2(NUM_LANES);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state_p0, state_nxt;
    logic [W-1:0]         word_p0;
    logic [NUM_LANES-1:0] rem_p0, rem_nxt;
    logic [IDX_W-1:0]     lane_p0, lane_nxt;
    logic [NUM_LANES-1:0] mask_in;
    logic                 in_fire, out_fire, last;

    function automatic logic [IDX_W-1:0] first_lane(input logic [NUM_LANES-1:0] m);
        first_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (m[i]) first_lane = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_LANES-1:0] clear_lowest(input logic [NUM_LANES-1:0] m);
        clear_lowest = m & (m - NUM_LANES'(1));
    endfunction

`ifdef UNPACK_MASK_EN
    assign mask_in = In_Mask;
`else
    assign mask_in = '1;
`endif

    // rem_p0 holds the enabled lanes strictly above the lane on the output
    assign last      = (rem_p0 == '0);
    assign Out_Valid = (state_p0 == EMIT);
    assign Out_Last  = Out_Valid && last;
    assign Out_Lane  = Out_Valid ? lane_p0 : '0;
    assign Out_Data  = Out_Valid ? word_p0[int'(lane_p0) * LANE_W +: LANE_W] : '0;
    assign In_Ready  = !Reset && ((state_p0 == IDLE) || (last && Out_Ready));
    assign in_fire   = In_Valid && In_Ready;
    assign out_fire  = Out_Valid && Out_Ready;

    always_comb begin
        state_nxt = state_p0;
        rem_nxt   = rem_p0;
        lane_nxt  = lane_p0;
        if (out_fire) begin
            if (last) begin
                state_nxt = IDLE;
            end else begin
                lane_nxt = first_lane(rem_p0);
                rem_nxt  = clear_lowest(rem_p0);
            end
        end
        // An empty mask is accepted but produces nothing
        if (in_fire) begin
            if (mask_in != '0) begin
                state_nxt = EMIT;
                lane_nxt  = first_lane(mask_in);
                rem_nxt   = clear_lowest(mask_in);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_p0 <= IDLE;
            rem_p0   <= '0;
            lane_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            rem_p0   <= rem_nxt;
            lane_p0  <= lane_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (in_fire) word_p0 <= In_Data;
    end

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Self-checking bench for word_byte_unpacker: directed tables, corner sequences and
// randomized traffic against a lane-queue reference model.
module tb_word_byte_unpacker;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    int tests = 0;
    int fails = 0;
    bit mchk  = 0;

    word_byte_unpacker #(.NUM_LANES(4), .LANE_W(8)) dut (
        .Clk(clk), .Reset(rst),
        .In_Valid(in_valid), .In_Ready(in_ready), .In_Data(in_data),
`ifdef UNPACK_MASK_EN
        .In_Mask(in_mask),
`endif
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Data(out_data),
        .Out_Lane(out_lane), .Out_Last(out_last)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: the lanes still owed by the word in flight
    typedef struct {logic [7:0] d; logic [1:0] l;} lane_t;
    lane_t q[$];

    function automatic logic [3:0] eff_mask();
`ifdef UNPACK_MASK_EN
        return in_mask;
`else
        return 4'hF;
`endif
    endfunction

    function automatic bit m_ready();
        return !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        if (!mchk) return;
        chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_out_data", 32'(out_data), 32'(q[0].d));
            chk("m_out_lane", 32'(out_lane), 32'(q[0].l));
            chk("m_out_last", 32'(out_last), 32'(q.size() == 1));
        end
    endtask

    task automatic model_update();
        bit fi, fo;
        logic [3:0] m;
        if (rst) begin
            q.delete();
        end else begin
            fi = in_valid && m_ready();
            fo = (q.size() != 0) && out_ready;
            m  = eff_mask();
            if (fo) void'(q.pop_front());
            if (fi) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) q.push_back('{in_data[8*i +: 8], 2'(i)});
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  mask;
        logic [2:0]  n;
        logic [31:0] d;   // expected bytes, first emitted in the top byte
        logic [7:0]  l;   // expected lanes, first emitted in the top pair
    } vec_t;

    vec_t tab[4];
    int   ntab;

    initial begin
        logic [7:0] ed[$];
        logic [1:0] el[$];
        bit         ela[$];
        int total, got, cyc, acc0, first_v, bubbles, idx;
        bit started;
        logic [5:0]  rdy_pat;
        logic [47:0] stall_d;
        logic [5:0]  stall_r;
        logic [31:0] rst_d;

        tab[0] = '{32'hDDCCBBAA, 4'hF, 3'd4, 32'hAABBCCDD, 8'b00_01_10_11};
        tab[1] = '{32'h44332211, 4'hF, 3'd4, 32'h11223344, 8'b00_01_10_11};
        tab[2] = '{32'h88776655, 4'hF, 3'd4, 32'h55667788, 8'b00_01_10_11};
        ntab = 3;
`ifdef UNPACK_MASK_EN
        tab[3] = '{32'hDDCCBBAA, 4'b1010, 3'd2, 32'hBBDD0000, 8'b01_11_00_00};
        ntab = 4;
`else
        tab[3] = '0;
`endif

        // Reset held two clocks
        rst = 1; in_valid = 0; in_data = 'x; in_mask = 4'hF; out_ready = 0;
        advance();
        mchk = 1;
        settle();
        advance();
        rst = 0;
        settle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_lane",  32'(out_lane),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        advance();

        // Back-to-back words from the table, consumer always ready
        total = 0;
        for (int v = 0; v < ntab; v++) begin
            for (int k = 0; k < int'(tab[v].n); k++) begin
                ed.push_back(tab[v].d[31 - 8*k -: 8]);
                el.push_back(tab[v].l[7 - 2*k -: 2]);
                ela.push_back(k == int'(tab[v].n) - 1);
            end
            total += int'(tab[v].n);
        end
        got = 0; cyc = 0; idx = 0; acc0 = -1; first_v = -1; bubbles = 0; started = 0;
        out_ready = 1;
        while (got < total && cyc < 80) begin
            in_valid = (idx < ntab);
            in_data  = (idx < ntab) ? tab[idx].word : 'x;
            in_mask  = (idx < ntab) ? tab[idx].mask : 'x;
            settle();
            if (out_valid) begin
                if (!started) first_v = cyc;
                started = 1;
                chk("tab_data", 32'(out_data), 32'(ed[got]));
                chk("tab_lane", 32'(out_lane), 32'(el[got]));
                chk("tab_last", 32'(out_last), 32'(ela[got]));
                if (out_data == 8'h44) chk("tab_reload_ready", 32'(in_ready), 32'd1);
                got++;
            end else if (started) begin
                bubbles++;
            end
            if (in_valid && in_ready) begin
                if (acc0 < 0) acc0 = cyc;
                idx++;
            end
            advance();
            cyc++;
        end
        chk("tab_all_lanes", 32'(got), 32'(total));
        chk("tab_latency", 32'(first_v - acc0), 32'd1);
        chk("tab_bubbles", 32'(bubbles), 32'd0);
        in_valid = 0; in_data = 'x;
        settle(); advance();

        // Consumer stalls mid-word
        in_valid = 1; in_data = 32'hDDCCBBAA; in_mask = 4'hF; out_ready = 0;
        settle();
        chk("stall_accept", 32'(in_ready), 32'd1);
        advance();
        in_valid = 0; in_data = 'x;
        rdy_pat = 6'b111001;
        stall_d = 48'hAA_BB_BB_BB_CC_DD;
        stall_r = 6'b100000;
        for (int k = 0; k < 6; k++) begin
            out_ready = rdy_pat[k];
            settle();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(stall_d[47 - 8*k -: 8]));
            chk("stall_in_ready", 32'(in_ready), 32'(stall_r[k]));
            advance();
        end
        settle();
        chk("stall_done", 32'(out_valid), 32'd0);
        advance();

        // Reset arrives while CC is on the output
        in_valid = 1; in_data = 32'hDDCCBBAA; out_ready = 1;
        settle(); advance();
        in_valid = 0; in_data = 'x;
        settle(); advance();
        settle(); advance();
        rst = 1; out_ready = 0;
        settle();
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        advance();
        rst = 0;
        settle();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1; in_data = 32'h00000001;
        advance();
        in_valid = 0; in_data = 'x; out_ready = 1;
        rst_d = 32'h01000000;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("midrst_data", 32'(out_data), 32'(rst_d[31 - 8*k -: 8]));
            chk("midrst_lane", 32'(out_lane), 32'(k));
            advance();
        end
        settle();
        chk("midrst_end", 32'(out_valid), 32'd0);
        advance();

`ifdef UNPACK_MASK_EN
        // Empty mask: swallowed without output
        in_valid = 1; in_data = 32'h12345678; in_mask = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("zmask_ready", 32'(in_ready), 32'd1);
            chk("zmask_valid", 32'(out_valid), 32'd0);
            advance();
        end
        in_valid = 0; in_data = 'x;
        settle();
        chk("zmask_after", 32'(out_valid), 32'd0);
        advance();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = in_valid ? $urandom : 'x;
            in_mask   = in_valid ? 4'($urandom) : 'x;
            out_ready = ($urandom_range(0, 3) != 0);
            settle();
            advance();
        end
        rst = 0; in_valid = 0; in_data = 'x; out_ready = 1;
        for (int c = 0; c < 6; c++) begin
            settle();
            advance();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
